// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite engine: screen geometry, coordinate/delta
// types, the 12-bit colour struct and the per-pixel tag carried down the pipeline.
package sprite_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef logic [9:0]         coord_t;
   typedef logic signed [10:0] delta_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   typedef struct packed {
      logic hit;
      logic border;
      logic hl_en;
   } tag_t;

   function automatic delta_t coord_delta(input coord_t pos, input coord_t origin);
      return delta_t'({1'b0, pos}) - delta_t'({1'b0, origin});
   endfunction

endpackage

// File: rtl/sprite_engine_if.sv
// Sprite ROM bus: the engine drives the address, the shared ROM returns a palette index.
interface sprite_engine_if #(
   parameter int AW    = 16,
   parameter int IDX_W = 4
);
   logic [AW-1:0]    rom_addr;
   logic [IDX_W-1:0] rom_data;

   modport master (output rom_addr, input rom_data);
   modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_palette.sv
// Combinational palette: maps a ROM palette index to a 12-bit colour, shared by all sprites.
module sprite_palette
   import sprite_pkg::*;
#(
   parameter int IDX_W = 4
) (
   input  logic [IDX_W-1:0] idx,
   output rgb_t             rgb
);

   localparam rgb_t PAL_TABLE [16] = '{
      12'h000, 12'hFFF, 12'h888, 12'h444, 12'hF00, 12'h0F0, 12'h00F, 12'hFF0,
      12'h0FF, 12'hF0F, 12'hA52, 12'hDB8, 12'h630, 12'hCCC, 12'h222, 12'hF80
   };

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      rgb = '0;
      for (int k = 0; k < 16; k++) begin
         if (int'(idx) == k) rgb = PAL_TABLE[k];
      end
   end

endmodule

// File: rtl/sprite_engine.sv
// Pipelined sprite blitter: hit test and ROM address (stage A), delay line matching ROM
// latency, then palette/transparency/blinking highlight border into registered outputs (stage B).
module sprite_engine
   import sprite_pkg::*;
#(
   parameter int   SPRITE_W        = 55,
   parameter int   SPRITE_H        = 55,
   parameter int   NUM_SPRITES     = 12,
   parameter int   ROM_LATENCY     = 1,
   parameter int   IDX_W           = 4,
   parameter int   TRANSPARENT_IDX = 0,
   parameter int   BLINK_FRAMES    = 16,
   parameter rgb_t HL_RGB          = 12'hFF0,
   localparam int  SEL_W           = $clog2(NUM_SPRITES),
   localparam int  AW              = $clog2(NUM_SPRITES * SPRITE_W * SPRITE_H)
) (
   input  logic             vga_clk,
   input  logic             Reset,
   input  logic             frame_start,
   input  coord_t           DrawX,
   input  coord_t           DrawY,
   input  coord_t           offsetX,
   input  coord_t           offsetY,
   input  logic [SEL_W-1:0] sprite_sel,
   input  logic             mirror,
   input  logic             highlight_en,
   sprite_engine_if.master  rom,
   output logic [3:0]       red,
   output logic [3:0]       green,
   output logic [3:0]       blue,
   output logic             sprite_on
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   delta_t                       dx, dy;
   logic                         hit_a, border_a;
   logic [AW-1:0]                rx, addr;
   logic [AW-1:0]                rom_addr_d, rom_addr_q;
   tag_t                         tag_a_d, tag_a_q;
   tag_t [ROM_LATENCY-1:0]       dly_d, dly_q;
   tag_t                         tag_b;
   logic                         border_hl;
   rgb_t                         pal_rgb, rgb_d, rgb_q;
   logic                         sprite_on_d, sprite_on_q;
   logic [CNT_W-1:0]             cnt_d, cnt_q;
   logic                         blink_d, blink_q;

   // Stage A: hit test and ROM address.
   always_comb begin
      dx = coord_delta(DrawX, offsetX);
      dy = coord_delta(DrawY, offsetY);
      // The sign bit is tested explicitly so a pixel left of/above the sprite is a miss.
      hit_a = !dx[10] && !dy[10] &&
              (dx[9:0] < 10'(SPRITE_W)) && (dy[9:0] < 10'(SPRITE_H)) &&
              ({1'b0, sprite_sel} < (SEL_W+1)'(NUM_SPRITES));
      border_a = hit_a && (dx[9:0] == 10'd0 || dy[9:0] == 10'd0 ||
                           dx[9:0] == 10'(SPRITE_W-1) || dy[9:0] == 10'(SPRITE_H-1));
      rx   = mirror ? AW'(SPRITE_W-1) - AW'(dx[9:0]) : AW'(dx[9:0]);
      addr = AW'(sprite_sel) * AW'(SPRITE_W*SPRITE_H) + AW'(dy[9:0]) * AW'(SPRITE_W) + rx;
      rom_addr_d = hit_a ? addr : '0;
      tag_a_d    = '{hit: hit_a, border: border_a, hl_en: highlight_en};
   end

   // Tags wait here while the ROM fetches the pixel for the same sample.
   always_comb begin
      dly_d    = '0;
      dly_d[0] = tag_a_q;
      for (int i = 1; i < ROM_LATENCY; i++) dly_d[i] = dly_q[i-1];
   end

   sprite_palette #(.IDX_W(IDX_W)) u_palette (
      .idx (rom.rom_data),
      .rgb (pal_rgb)
   );

   // Stage B: transparency key and highlight border.
   always_comb begin
      tag_b       = dly_q[ROM_LATENCY-1];
      border_hl   = tag_b.border && tag_b.hl_en && blink_q;
      sprite_on_d = tag_b.hit && (border_hl || rom.rom_data != IDX_W'(TRANSPARENT_IDX));
      rgb_d       = border_hl ? HL_RGB : (sprite_on_d ? pal_rgb : '0);
   end

   // Frame counter; runs whether or not highlighting is enabled.
   always_comb begin
      cnt_d   = cnt_q;
      blink_d = blink_q;
      if (frame_start) begin
         if (cnt_q == CNT_W'(BLINK_FRAMES-1)) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge vga_clk) begin
      if (Reset) begin
         rom_addr_q  <= '0;
         tag_a_q     <= '0;
         dly_q       <= '0;
         rgb_q       <= '0;
         sprite_on_q <= 1'b0;
         cnt_q       <= '0;
         blink_q     <= 1'b0;
      end else begin
         rom_addr_q  <= rom_addr_d;
         tag_a_q     <= tag_a_d;
         dly_q       <= dly_d;
         rgb_q       <= rgb_d;
         sprite_on_q <= sprite_on_d;
         cnt_q       <= cnt_d;
         blink_q     <= blink_d;
      end
   end

   assign rom.rom_addr        = rom_addr_q;
   assign {red, green, blue}  = rgb_q;
   assign sprite_on           = sprite_on_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Directed bench for sprite_engine with a latency-1 ROM model whose entry k holds k mod 16.
module tb_sprite_engine;
   import sprite_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_start;
   coord_t     DrawX, DrawY, offsetX, offsetY;
   logic [3:0] sprite_sel;
   logic       mirror, highlight_en;
   logic [3:0] red, green, blue;
   logic       sprite_on;
   logic       rom_blank;

   int n_checks = 0;
   int n_errors = 0;

   sprite_engine_if #(.AW(16), .IDX_W(4)) rom_if ();

   sprite_engine dut (
      .vga_clk      (clk),
      .Reset        (rst),
      .frame_start  (frame_start),
      .DrawX        (DrawX),
      .DrawY        (DrawY),
      .offsetX      (offsetX),
      .offsetY      (offsetY),
      .sprite_sel   (sprite_sel),
      .mirror       (mirror),
      .highlight_en (highlight_en),
      .rom          (rom_if),
      .red          (red),
      .green        (green),
      .blue         (blue),
      .sprite_on    (sprite_on)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rom_if.rom_data <= rom_blank ? 4'd0 : rom_if.rom_addr[3:0];

   function automatic int pal_ref(input int idx);
      case (idx)
         1: return 'hFFF;   2: return 'h888;   3: return 'h444;   4: return 'hF00;
         5: return 'h0F0;   6: return 'h00F;   7: return 'hFF0;   8: return 'h0FF;
         9: return 'hF0F;  10: return 'hA52;  11: return 'hDB8;  12: return 'h630;
        13: return 'hCCC;  14: return 'h222;  15: return 'hF80;
         default: return 0;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one pixel, check the address one cycle later and the colour three cycles later.
   task automatic probe(input string tag, input int x, input int y,
                        input int exp_addr, input bit exp_on, input int exp_rgb);
      @(negedge clk);
      DrawX = 10'(x);
      DrawY = 10'(y);
      @(negedge clk);
      check({tag, ".addr"}, 32'(rom_if.rom_addr), exp_addr);
      repeat (2) @(negedge clk);
      check({tag, ".on"}, 32'(sprite_on), 32'(exp_on));
      check({tag, ".rgb"}, 32'({red, green, blue}), exp_rgb);
   endtask

   task automatic pulse_frames(input int n);
      repeat (n) begin
         @(negedge clk) frame_start = 1'b1;
         @(negedge clk) frame_start = 1'b0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; frame_start = 1'b0;
      DrawX = 10'd0; DrawY = 10'd100; offsetX = 10'd100; offsetY = 10'd100;
      sprite_sel = 4'd0; mirror = 1'b0; highlight_en = 1'b0; rom_blank = 1'b0;
      repeat (3) @(negedge clk);
      check("reset.addr", 32'(rom_if.rom_addr), 0);
      check("reset.on", 32'(sprite_on), 0);
      check("reset.rgb", 32'({red, green, blue}), 0);
      rst = 1'b0;

      // Sweep x = 99..156 on the top row; address and colour checked against the pipeline delay.
      for (int n = 0; n <= 60; n++) begin
         @(negedge clk);
         if (n >= 1 && n <= 58) begin
            int x;
            x = 99 + n - 1;
            check("sweep.addr", 32'(rom_if.rom_addr), (x >= 100 && x <= 154) ? x - 100 : 0);
         end
         if (n >= 3) begin
            int x, idx;
            bit on;
            x   = 99 + n - 3;
            idx = (x >= 100 && x <= 154) ? (x - 100) % 16 : 0;
            on  = (x >= 100 && x <= 154) && idx != 0;
            check("sweep.on", 32'(sprite_on), 32'(on));
            check("sweep.rgb", 32'({red, green, blue}), on ? pal_ref(idx) : 0);
         end
         if (n < 58) DrawX = 10'(99 + n);
      end

      // Exact latency: an opaque pixel after a run of misses appears on the third cycle.
      @(negedge clk) DrawX = 10'd101;
      @(negedge clk) check("lat.t1", 32'(sprite_on), 0);
      @(negedge clk) check("lat.t2", 32'(sprite_on), 0);
      @(negedge clk) check("lat.t3", 32'(sprite_on), 1);
      check("lat.rgb", 32'({red, green, blue}), 'hFFF);

      sprite_sel = 4'd5; mirror = 1'b1;
      probe("sel5_mirror", 100, 101, 15234, 1'b1, 'h888);
      sprite_sel = 4'd0;
      probe("mirror_right", 154, 102, 110, 1'b1, 'h222);
      mirror = 1'b0; sprite_sel = 4'd11;
      probe("sel11", 120, 120, 34395, 1'b1, 'hDB8);
      sprite_sel = 4'd13;
      probe("sel13_miss", 120, 120, 0, 1'b0, 0);
      sprite_sel = 4'd0;
      probe("y_last", 100, 154, 2970, 1'b1, 'hA52);
      probe("y_past", 100, 155, 0, 1'b0, 0);
      probe("y_screen", 100, SCREEN_H - 1, 0, 1'b0, 0);
      offsetX = 10'd300;
      probe("neg_dx", 200, 100, 0, 1'b0, 0);
      offsetX = 10'd620;
      probe("clip", SCREEN_W - 1, 100, 19, 1'b1, 'h444);
      offsetX = 10'd100;

      // Transparency and the blinking border.
      rom_blank = 1'b1;
      probe("transp_in", 120, 120, 1120, 1'b0, 0);
      probe("transp_brd", 100, 110, 550, 1'b0, 0);
      highlight_en = 1'b1;
      probe("hl_ph0", 100, 110, 550, 1'b0, 0);
      pulse_frames(15);
      probe("hl_f15", 100, 110, 550, 1'b0, 0);
      pulse_frames(1);
      probe("hl_f16", 100, 110, 550, 1'b1, 'hFF0);
      probe("hl_interior", 120, 120, 1120, 1'b0, 0);
      pulse_frames(15);
      probe("hl_f31", 100, 110, 550, 1'b1, 'hFF0);
      pulse_frames(1);
      probe("hl_f32", 100, 110, 550, 1'b0, 0);

      // Mid-sprite reset with a coincident frame_start, then pipeline refill.
      rom_blank = 1'b0;
      pulse_frames(5);
      probe("pre_rst", 101, 101, 56, 1'b1, 'h0FF);
      @(negedge clk) begin rst = 1'b1; frame_start = 1'b1; end
      @(negedge clk);
      check("rst.on", 32'(sprite_on), 0);
      check("rst.rgb", 32'({red, green, blue}), 0);
      check("rst.addr", 32'(rom_if.rom_addr), 0);
      frame_start = 1'b0;
      rst = 1'b0;
      @(negedge clk) check("refill.1", 32'(sprite_on), 0);
      @(negedge clk) check("refill.2", 32'(sprite_on), 0);
      @(negedge clk) check("refill.3", 32'(sprite_on), 1);
      check("refill.rgb", 32'({red, green, blue}), 'h0FF);

      rom_blank = 1'b1;
      pulse_frames(15);
      probe("post_rst_f15", 100, 110, 550, 1'b0, 0);
      pulse_frames(1);
      probe("post_rst_f16", 100, 110, 550, 1'b1, 'hFF0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
